perf_window_sequencer: RTL and testbench
========================================

Name: perf_window_sequencer

Overview:
- Controls window-based sampling of the pipeline's free-running performance counters (instructions, cycles, stalls, branch mispredicts, ...).
- Software or the testbench arms it with a window length. It takes a baseline snapshot, then emits one delta record per window.
- Records are buffered in a small FIFO and drained by a valid/ready consumer (logger/trace port).
- Sits between the core's counter bank and the performance reporting path.

Parameters:
- NUM_CNT, 4, number of counters sampled; index 0 = instructions, 1 = stalls.
- CNT_W, 32, counter and delta width.
- FIFO_DEPTH, 4, sample FIFO entries; power of 2, ≥ 2.
- DEF_WINDOW, 1000, window length loaded at reset, in cyc_en pulses.

Ports:
- clk, in, 1, clock.
- reset, in, 1, asynchronous, active-high reset.
- cfg_we, in, 1, write cfg_window; accepted only in IDLE.
- cfg_window, in, 32, window length; 0 is treated as 1.
- cmd_start, in, 1, start sampling (pulse).
- cmd_stop, in, 1, stop sampling (pulse).
- cyc_en, in, 1, window tick; counts one window cycle.
- cnt_in, in, NUM_CNT x CNT_W, live counter values.
- smp_valid, out, 1, FIFO head valid.
- smp_ready, in, 1, consumer accepts head.
- smp_delta, out, NUM_CNT x CNT_W, per-counter delta for the window.
- smp_cycles, out, 32, cyc_en pulses covered by the record.
- smp_seq, out, 16, record sequence number.
- smp_partial, out, 1, record closed by stop before the window completed.
- drop_count, out, 16, records lost to a full FIFO; saturating.
- busy, out, 1, state != IDLE.
- state_o, out, 2, current FSM state.

Behaviour:
- Reset values: all outputs 0; state IDLE; window_reg = DEF_WINDOW; seq = 0; FIFO empty.
- State machine, states IDLE, ARM, RUN, FLUSH:
  - IDLE: cmd_start → ARM. cfg_we loads window_reg; if cfg_window is 0, window_reg = 1.
  - ARM (1 cycle): base[i] <= cnt_in[i]; remaining <= window_reg; elapsed <= 0 → RUN.
  - RUN, on each cyc_en: remaining--, elapsed++.
    - When remaining == 1 and cyc_en, capture in the same cycle.
    - Capture: delta[i] = cnt_in[i] - base[i], modulo 2^CNT_W, so counter wrap yields the correct delta.
    - Capture then sets base <= cnt_in, remaining <= window_reg, elapsed <= 0, and stays in RUN.
    - With cyc_en tied high, records close exactly every window_reg cycles.
  - RUN, on cmd_stop: if elapsed > 0 or cyc_en this cycle, push a partial record (smp_partial = 1, smp_cycles = elapsed including this cycle's tick). → FLUSH.
  - FLUSH: waits until the FIFO is empty → IDLE. cmd_start is ignored.
  - ARM, on cmd_stop: → IDLE with no record.
- Simultaneous events:
  - cmd_start and cmd_stop together: stop wins; in IDLE nothing happens.
  - Capture and cmd_stop in the same cycle: push the full record only (partial = 0), then FLUSH.
- Push rules:
  - Every push carries smp_seq = seq, and seq increments (wraps at 16 bits) whether or not the record is dropped.
  - FIFO full at push: the record is discarded and drop_count++, saturating at 0xFFFF.
  - A push is allowed in the same cycle as a pop when full: pop first, so no drop.
- FIFO outputs:
  - Registered; smp_valid is high while the FIFO is non-empty.
  - Head is stable while smp_valid && !smp_ready.
  - First record is visible 1 cycle after its capture cycle.
- cfg_we outside IDLE is ignored; window_reg is unchanged.
- reset mid-operation: immediately returns to the reset values; FIFO contents are lost.

Optional Feature:
- Macro: PERF_SEQ_STALL_ALERT_EN.
- When defined, adds:
  - Port stall_thresh, input, CNT_W.
  - Port stall_alert, output, 1, reset 0.
  - stall_alert pulses for exactly 1 cycle on each pushed-or-dropped record whose delta[1] > stall_thresh. It is evaluated at capture, independent of FIFO state.
- When undefined: neither port exists, and there is no comparator logic.

Decomposition:
- perf_pkg holds:
  - perf_seq_state_t enum: IDLE = 0, ARM = 1, RUN = 2, FLUSH = 3.
  - PERF_IDX_INSTR = 0 and PERF_IDX_STALL = 1 constants.
  - PERF_SEQ_W = 16.
- Sub-module perf_sample_fifo: parameterized synchronous FIFO (data width, depth) with push/pop/full/empty. The sequencer instantiates it with record width NUM_CNT*CNT_W + 32 + 16 + 1.

Test Plan:
- Basic windows: cfg_window = 10, cyc_en = 1, cnt_in[0] incrementing by 1 per cycle, start → records every 10 cycles; delta[0] = 10, smp_cycles = 10, seq 0, 1, 2.
- Counter wrap: base[0] = 0xFFFFFFF8, counter +2 per cycle, window 8 → delta[0] = 16.
- Overflow: smp_ready = 0, window 2, 6 windows → first 4 records retained (seq 0–3), drop_count = 2; then drain and check seq 0–3 in order with held heads.
- Partial stop: window 100, stop after 37 ticks → one record with partial = 1, smp_cycles = 37; busy falls after the FIFO drains; state IDLE.
- Edge and config cases: cfg_window = 0 → records every cycle. cfg_we during RUN → ignored. Start + stop in the same cycle from IDLE → stays IDLE.
- Reset mid-RUN with 2 records queued → smp_valid = 0, drop_count = 0, window_reg = 1000; with PERF_SEQ_STALL_ALERT_EN, thresh = 5 and a window with stall delta 6 → a single-cycle stall_alert.

Source files
------------

// File: rtl/perf_pkg.sv
// Shared types and constants for the performance-counter window sequencer.
package perf_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        RUN   = 2'd2,
        FLUSH = 2'd3
    } perf_seq_state_t;

    localparam int PERF_IDX_INSTR = 0;
    localparam int PERF_IDX_STALL = 1;
    localparam int PERF_SEQ_W     = 16;

endpackage

// File: rtl/perf_sample_fifo.sv
// Synchronous record FIFO; a push into a full FIFO succeeds when a pop happens in the same cycle.
module perf_sample_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              wr_en;
    logic              rd_en;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/perf_window_sequencer.sv
// Window-based sampler of free-running performance counters emitting per-window delta records.
// Optional stall-threshold alert output enabled by defining PERF_SEQ_STALL_ALERT_EN.
module perf_window_sequencer
    import perf_pkg::*;
#(
    parameter int NUM_CNT    = 4,
    parameter int CNT_W      = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int DEF_WINDOW = 1000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cfg_we,
    input  logic [31:0]              cfg_window,
    input  logic                     cmd_start,
    input  logic                     cmd_stop,
    input  logic                     cyc_en,
    input  logic [NUM_CNT*CNT_W-1:0] cnt_in,
    output logic                     smp_valid,
    input  logic                     smp_ready,
    output logic [NUM_CNT*CNT_W-1:0] smp_delta,
    output logic [31:0]              smp_cycles,
    output logic [PERF_SEQ_W-1:0]    smp_seq,
    output logic                     smp_partial,
    output logic [15:0]              drop_count,
    output logic                     busy,
    output logic [1:0]               state_o
`ifdef PERF_SEQ_STALL_ALERT_EN
    ,
    input  logic [CNT_W-1:0]         stall_thresh,
    output logic                     stall_alert
`endif
);

    localparam int SAMP_W = NUM_CNT * CNT_W;
    localparam int REC_W  = SAMP_W + 32 + PERF_SEQ_W + 1;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    perf_seq_state_t       state;
    logic [31:0]           window_reg;
    logic [31:0]           remaining;
    logic [31:0]           elapsed;
    logic [SAMP_W-1:0]     base;
    logic [SAMP_W-1:0]     delta;
    logic [PERF_SEQ_W-1:0] seq;

    logic                  capture;
    logic                  stop_partial;
    logic                  push_req;
    logic                  pop;
    logic                  drop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [31:0]           rec_cycles;
    logic [REC_W-1:0]      rec_in;
    logic [REC_W-1:0]      rec_head;

    // Modulo subtraction makes a wrapped counter still produce the true delta.
    always_comb begin
        delta = '0;
        for (int i = 0; i < NUM_CNT; i++) begin
            delta[i*CNT_W +: CNT_W] = cnt_in[i*CNT_W +: CNT_W] - base[i*CNT_W +: CNT_W];
        end
    end

    assign capture      = (state == RUN) && cyc_en && (remaining == 32'd1);
    assign stop_partial = (state == RUN) && cmd_stop && !capture && ((elapsed != 32'd0) || cyc_en);
    assign push_req     = capture || stop_partial;
    assign rec_cycles   = elapsed + {31'd0, cyc_en};
    assign rec_in       = {delta, rec_cycles, seq, !capture};

    assign pop  = smp_valid && smp_ready;
    assign drop = push_req && fifo_full && !pop;

    perf_sample_fifo #(
        .DATA_W (REC_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_req),
        .pop   (pop),
        .din   (rec_in),
        .dout  (rec_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Head fields are forced to zero while empty so stale storage never leaks out.
    assign smp_valid = !fifo_empty;
    assign {smp_delta, smp_cycles, smp_seq, smp_partial} = fifo_empty ? '0 : rec_head;
    assign busy      = (state != IDLE);
    assign state_o   = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            window_reg <= 32'(DEF_WINDOW);
            remaining  <= '0;
            elapsed    <= '0;
            seq        <= '0;
            drop_count <= '0;
        end else begin
            if (push_req) seq <= seq + PERF_SEQ_W'(1);
            if (drop)     drop_count <= sat_inc16(drop_count);

            case (state)
                IDLE: begin
                    if (cfg_we) window_reg <= (cfg_window == 32'd0) ? 32'd1 : cfg_window;
                    if (cmd_start && !cmd_stop) state <= ARM;
                end
                ARM: begin
                    if (cmd_stop) begin
                        state <= IDLE;
                    end else begin
                        remaining <= window_reg;
                        elapsed   <= '0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (capture) begin
                        remaining <= window_reg;
                        elapsed   <= '0;
                        if (cmd_stop) state <= FLUSH;
                    end else if (cmd_stop) begin
                        state <= FLUSH;
                    end else if (cyc_en) begin
                        remaining <= remaining - 32'd1;
                        elapsed   <= elapsed + 32'd1;
                    end
                end
                FLUSH: begin
                    if (fifo_empty) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Baseline snapshot is pure data; the FSM decides when it is meaningful.
    always_ff @(posedge clk) begin
        if ((state == ARM && !cmd_stop) || capture) base <= cnt_in;
    end

`ifdef PERF_SEQ_STALL_ALERT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) stall_alert <= 1'b0;
        else       stall_alert <= push_req && (delta[PERF_IDX_STALL*CNT_W +: CNT_W] > stall_thresh);
    end
`endif

endmodule

// File: tb/tb_perf_window_sequencer.sv
// Directed self-checking bench for perf_window_sequencer (default 4 x 32-bit counters).
module tb_perf_window_sequencer;

    logic         clk = 1'b0;
    logic         reset;
    logic         cfg_we;
    logic [31:0]  cfg_window;
    logic         cmd_start;
    logic         cmd_stop;
    logic         cyc_en;
    logic [127:0] cnt_in;
    logic         smp_valid;
    logic         smp_ready;
    logic [127:0] smp_delta;
    logic [31:0]  smp_cycles;
    logic [15:0]  smp_seq;
    logic         smp_partial;
    logic [15:0]  drop_count;
    logic         busy;
    logic [1:0]   state_o;
`ifdef PERF_SEQ_STALL_ALERT_EN
    logic [31:0]  stall_thresh;
    logic         stall_alert;
`endif

    logic [31:0] cnt [4];
    logic [31:0] inc [4];
    int n_vec  = 0;
    int n_miss = 0;

    assign cnt_in = {cnt[3], cnt[2], cnt[1], cnt[0]};

    always #5 clk = ~clk;

    perf_window_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_we      (cfg_we),
        .cfg_window  (cfg_window),
        .cmd_start   (cmd_start),
        .cmd_stop    (cmd_stop),
        .cyc_en      (cyc_en),
        .cnt_in      (cnt_in),
        .smp_valid   (smp_valid),
        .smp_ready   (smp_ready),
        .smp_delta   (smp_delta),
        .smp_cycles  (smp_cycles),
        .smp_seq     (smp_seq),
        .smp_partial (smp_partial),
        .drop_count  (drop_count),
        .busy        (busy),
        .state_o     (state_o)
`ifdef PERF_SEQ_STALL_ALERT_EN
        ,
        .stall_thresh(stall_thresh),
        .stall_alert (stall_alert)
`endif
    );

    // One clock: sample point is 1 time unit after the rising edge, then counters advance.
    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) cnt[i] = cnt[i] + inc[i];
    endtask

    task automatic do_reset();
        reset = 1'b1; cfg_we = 1'b0; cfg_window = '0; cmd_start = 1'b0; cmd_stop = 1'b0;
        cyc_en = 1'b0; smp_ready = 1'b0;
`ifdef PERF_SEQ_STALL_ALERT_EN
        stall_thresh = '0;
`endif
        for (int i = 0; i < 4; i++) begin cnt[i] = '0; inc[i] = '0; end
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic configure(input logic [31:0] w);
        cfg_we = 1'b1; cfg_window = w;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic start();
        cmd_start = 1'b1;
        step();
        cmd_start = 1'b0;
    endtask

    task automatic wait_valid(input int max, output int n);
        n = -1;
        for (int t = 1; t <= max; t++) begin
            step();
            if (smp_valid) begin n = t; break; end
        end
    endtask

    task automatic wait_idle(input int max, output int n);
        n = -1;
        for (int t = 1; t <= max; t++) begin
            step();
            if (!busy) begin n = t; break; end
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++; if (smp_valid !== 1'b0) begin n_miss++; $display("FAIL rst_valid got %0b want 0", smp_valid); end
        n_vec++; if (busy !== 1'b0) begin n_miss++; $display("FAIL rst_busy got %0b want 0", busy); end
        n_vec++; if (state_o !== 2'd0) begin n_miss++; $display("FAIL rst_state got %0d want 0", state_o); end
        n_vec++; if (drop_count !== 16'd0) begin n_miss++; $display("FAIL rst_drop got %0d want 0", drop_count); end
        n_vec++; if ({smp_delta, smp_cycles, smp_seq, smp_partial} !== '0) begin n_miss++; $display("FAIL rst_record got %h want 0", smp_delta); end
    endtask

    task automatic test_basic();
        int n;
        do_reset();
        configure(32'd10);
        inc[0] = 32'd1; cyc_en = 1'b1; smp_ready = 1'b1;
        start();
        for (int k = 0; k < 3; k++) begin
            wait_valid(20, n);
            n_vec++; if (n !== (k == 0 ? 11 : 10)) begin n_miss++; $display("FAIL basic_latency rec %0d got %0d want %0d", k, n, (k == 0 ? 11 : 10)); end
            n_vec++; if (smp_seq !== 16'(k)) begin n_miss++; $display("FAIL basic_seq got %0d want %0d", smp_seq, k); end
            n_vec++; if (smp_delta[31:0] !== 32'd10) begin n_miss++; $display("FAIL basic_delta got %0d want 10", smp_delta[31:0]); end
            n_vec++; if (smp_cycles !== 32'd10) begin n_miss++; $display("FAIL basic_cycles got %0d want 10", smp_cycles); end
            n_vec++; if (smp_partial !== 1'b0) begin n_miss++; $display("FAIL basic_partial got %0b want 0", smp_partial); end
        end
        cyc_en = 1'b0; cmd_stop = 1'b1;
        step();
        cmd_stop = 1'b0;
        wait_idle(10, n);
        n_vec++; if (n < 0) begin n_miss++; $display("FAIL basic_idle got busy=%0b want 0", busy); end
    endtask

    task automatic test_wrap();
        int n;
        do_reset();
        configure(32'd8);
        cnt[0] = 32'hFFFF_FFF6; inc[0] = 32'd2; cyc_en = 1'b1; smp_ready = 1'b1;
        start();
        wait_valid(20, n);
        n_vec++; if (n !== 9) begin n_miss++; $display("FAIL wrap_latency got %0d want 9", n); end
        n_vec++; if (smp_delta[31:0] !== 32'd16) begin n_miss++; $display("FAIL wrap_delta got %0d want 16", smp_delta[31:0]); end
        n_vec++; if (smp_cycles !== 32'd8) begin n_miss++; $display("FAIL wrap_cycles got %0d want 8", smp_cycles); end
        cyc_en = 1'b0; cmd_stop = 1'b1;
        step();
        cmd_stop = 1'b0;
        wait_idle(10, n);
    endtask

    task automatic test_overflow();
        int n;
        do_reset();
        configure(32'd2);
        inc[0] = 32'd1; cyc_en = 1'b1; smp_ready = 1'b0;
        start();
        repeat (13) step();
        n_vec++; if (drop_count !== 16'd2) begin n_miss++; $display("FAIL ovf_drop got %0d want 2", drop_count); end
        cyc_en = 1'b0; cmd_stop = 1'b1;
        step();
        cmd_stop = 1'b0;
        n_vec++; if (state_o !== 2'd3) begin n_miss++; $display("FAIL ovf_flush_state got %0d want 3", state_o); end
        for (int k = 0; k < 4; k++) begin
            n_vec++; if (smp_valid !== 1'b1) begin n_miss++; $display("FAIL ovf_valid rec %0d got %0b want 1", k, smp_valid); end
            n_vec++; if (smp_seq !== 16'(k)) begin n_miss++; $display("FAIL ovf_seq got %0d want %0d", smp_seq, k); end
            n_vec++; if (smp_delta[31:0] !== 32'd2) begin n_miss++; $display("FAIL ovf_delta got %0d want 2", smp_delta[31:0]); end
            step();
            n_vec++; if (smp_seq !== 16'(k)) begin n_miss++; $display("FAIL ovf_hold got %0d want %0d", smp_seq, k); end
            smp_ready = 1'b1;
            step();
            smp_ready = 1'b0;
        end
        n_vec++; if (smp_valid !== 1'b0) begin n_miss++; $display("FAIL ovf_drained got %0b want 0", smp_valid); end
        wait_idle(10, n);
        n_vec++; if (state_o !== 2'd0 || drop_count !== 16'd2) begin n_miss++; $display("FAIL ovf_end got state=%0d drop=%0d want 0/2", state_o, drop_count); end
    endtask

    task automatic test_partial();
        int n;
        do_reset();
        configure(32'd100);
        inc[0] = 32'd1; cyc_en = 1'b1; smp_ready = 1'b0;
        start();
        repeat (37) step();
        cmd_stop = 1'b1;
        step();
        cmd_stop = 1'b0; cyc_en = 1'b0;
        n_vec++; if (smp_valid !== 1'b1) begin n_miss++; $display("FAIL part_valid got %0b want 1", smp_valid); end
        n_vec++; if (smp_partial !== 1'b1) begin n_miss++; $display("FAIL part_flag got %0b want 1", smp_partial); end
        n_vec++; if (smp_cycles !== 32'd37) begin n_miss++; $display("FAIL part_cycles got %0d want 37", smp_cycles); end
        n_vec++; if (smp_delta[31:0] !== 32'd37) begin n_miss++; $display("FAIL part_delta got %0d want 37", smp_delta[31:0]); end
        n_vec++; if (busy !== 1'b1 || state_o !== 2'd3) begin n_miss++; $display("FAIL part_flush got busy=%0b state=%0d want 1/3", busy, state_o); end
        smp_ready = 1'b1;
        wait_idle(10, n);
        n_vec++; if (n !== 2) begin n_miss++; $display("FAIL part_idle_delay got %0d want 2", n); end
        n_vec++; if (state_o !== 2'd0 || smp_valid !== 1'b0) begin n_miss++; $display("FAIL part_end got state=%0d valid=%0b want 0/0", state_o, smp_valid); end
    endtask

    task automatic test_edges();
        int n;
        do_reset();
        configure(32'd0);
        inc[0] = 32'd1; cyc_en = 1'b1; smp_ready = 1'b1;
        start();
        step();
        for (int k = 0; k < 6; k++) begin
            if (k == 3) begin cfg_we = 1'b1; cfg_window = 32'd5; end
            step();
            cfg_we = 1'b0;
            n_vec++; if (smp_valid !== 1'b1 || smp_seq !== 16'(k)) begin n_miss++; $display("FAIL edge_win1 rec %0d got valid=%0b seq=%0d want 1/%0d", k, smp_valid, smp_seq, k); end
            n_vec++; if (smp_cycles !== 32'd1 || smp_delta[31:0] !== 32'd1) begin n_miss++; $display("FAIL edge_win1_data got cyc=%0d delta=%0d want 1/1", smp_cycles, smp_delta[31:0]); end
        end
        cyc_en = 1'b0; cmd_stop = 1'b1;
        step();
        cmd_stop = 1'b0;
        wait_idle(10, n);
        n_vec++; if (n < 0) begin n_miss++; $display("FAIL edge_idle got busy=%0b want 0", busy); end
        cmd_start = 1'b1; cmd_stop = 1'b1;
        step();
        cmd_start = 1'b0; cmd_stop = 1'b0;
        n_vec++; if (state_o !== 2'd0 || busy !== 1'b0) begin n_miss++; $display("FAIL edge_startstop got state=%0d busy=%0b want 0/0", state_o, busy); end
        step();
        n_vec++; if (state_o !== 2'd0) begin n_miss++; $display("FAIL edge_startstop2 got %0d want 0", state_o); end
    endtask

    task automatic test_reset_mid();
        int n;
        do_reset();
        configure(32'd2);
        inc[0] = 32'd1; cyc_en = 1'b1; smp_ready = 1'b0;
        start();
        repeat (5) step();
        cyc_en = 1'b0;
        n_vec++; if (smp_valid !== 1'b1 || smp_seq !== 16'd0) begin n_miss++; $display("FAIL rmid_queued got valid=%0b seq=%0d want 1/0", smp_valid, smp_seq); end
        #2 reset = 1'b1;
        #1;
        n_vec++; if (smp_valid !== 1'b0 || state_o !== 2'd0) begin n_miss++; $display("FAIL rmid_async got valid=%0b state=%0d want 0/0", smp_valid, state_o); end
        step();
        reset = 1'b0;
        n_vec++; if (drop_count !== 16'd0 || busy !== 1'b0) begin n_miss++; $display("FAIL rmid_clear got drop=%0d busy=%0b want 0/0", drop_count, busy); end
        cyc_en = 1'b1; smp_ready = 1'b1;
        start();
        wait_valid(1100, n);
        n_vec++; if (n !== 1001) begin n_miss++; $display("FAIL rmid_defwin got %0d want 1001", n); end
        n_vec++; if (smp_cycles !== 32'd1000 || smp_seq !== 16'd0) begin n_miss++; $display("FAIL rmid_rec got cyc=%0d seq=%0d want 1000/0", smp_cycles, smp_seq); end
        cyc_en = 1'b0; cmd_stop = 1'b1;
        step();
        cmd_stop = 1'b0;
        wait_idle(10, n);
    endtask

`ifdef PERF_SEQ_STALL_ALERT_EN
    task automatic test_stall_alert();
        int n;
        do_reset();
        stall_thresh = 32'd5;
        configure(32'd3);
        inc[0] = 32'd1; inc[1] = 32'd2; cyc_en = 1'b1; smp_ready = 1'b1;
        start();
        repeat (3) step();
        n_vec++; if (stall_alert !== 1'b0) begin n_miss++; $display("FAIL alert_pre got %0b want 0", stall_alert); end
        step();
        n_vec++; if (stall_alert !== 1'b1 || smp_delta[63:32] !== 32'd6) begin n_miss++; $display("FAIL alert_pulse got %0b delta=%0d want 1/6", stall_alert, smp_delta[63:32]); end
        step();
        n_vec++; if (stall_alert !== 1'b0) begin n_miss++; $display("FAIL alert_post got %0b want 0", stall_alert); end
        cyc_en = 1'b0; cmd_stop = 1'b1;
        step();
        cmd_stop = 1'b0;
        wait_idle(10, n);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_overflow();
        test_partial();
        test_edges();
        test_reset_mid();
`ifdef PERF_SEQ_STALL_ALERT_EN
        test_stall_alert();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
